// File: rtl/ov5640_cfg_seq.sv
// OV5640 register-initialisation sequencer: walks a {addr,data} table and issues one
// 16-bit-address single-byte I2C write per entry; addr 16'hFFFF entries are delay markers.
module ov5640_cfg_seq #(
    parameter logic [7:0] DEV_ADDR = 8'h78,
    parameter int         REG_NUM  = 250,
    parameter int         PWR_WAIT = 1_000_000,
    parameter int         GAP      = 100,
    parameter int         DLY_UNIT = 50_000,
    parameter int         TIMEOUT  = 20_000
) (
    input  logic        clk_4x,
    input  logic        rst,
    input  logic        cfg_start,
    output logic [7:0]  cfg_index,
    input  logic [23:0] cfg_data,
    output logic        iic_exce_st,
    output logic [7:0]  iic_dev_addr,
    output logic        iic_ctrl_w_r,
    output logic        iic_addr_bit,
    output logic [2:0]  iic_wr_model,
    output logic        iic_series,
    output logic [15:0] iic_data_addr,
    output logic [7:0]  iic_data_in,
    input  logic        iic_exce_done,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        timeout_err,
    output logic [3:0]  cfg_state
);

    typedef enum logic [3:0] {
        S_PWR    = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_ISSUE  = 4'd3,
        S_WAIT   = 4'd4,
        S_DELAY  = 4'd5,
        S_GAP    = 4'd6,
        S_NEXT   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    localparam logic [31:0] PWR_LAST = 32'(PWR_WAIT - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [31:0] DLY_MUL  = 32'(DLY_UNIT);
    localparam logic [7:0]  LAST_IDX = 8'(REG_NUM - 1);

    state_t      state;
    logic [31:0] cnt;
    logic [7:0]  dly_data;
    logic [31:0] dly_len;

    assign dly_len      = {24'd0, dly_data} * DLY_MUL;
    assign cfg_state    = state;
    assign iic_dev_addr = DEV_ADDR;
    assign iic_ctrl_w_r = 1'b0;
    assign iic_addr_bit = 1'b1;
    assign iic_wr_model = 3'b001;
    assign iic_series   = 1'b0;

    always_ff @(posedge clk_4x or negedge rst) begin
        if (!rst) begin
            state         <= S_PWR;
            cnt           <= 32'd0;
            dly_data      <= 8'd0;
            cfg_index     <= 8'd0;
            iic_exce_st   <= 1'b0;
            iic_data_addr <= 16'd0;
            iic_data_in   <= 8'd0;
            cfg_busy      <= 1'b1;
            cfg_done      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                S_PWR: begin
                    if (cnt == PWR_LAST) begin
                        cnt   <= 32'd0;
                        state <= S_FETCH1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                // One settle cycle lets a registered table ROM catch up with cfg_index.
                S_FETCH1: state <= S_FETCH2;
                S_FETCH2: begin
                    dly_data <= cfg_data[7:0];
                    if (cfg_data[23:8] == 16'hFFFF) begin
                        cnt   <= 32'd0;
                        state <= (cfg_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
                    end else begin
                        // Registered so the address/data and start pulse appear together in ISSUE.
                        iic_data_addr <= cfg_data[23:8];
                        iic_data_in   <= cfg_data[7:0];
                        iic_exce_st   <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    iic_exce_st <= 1'b0;
                    cnt         <= 32'd0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (iic_exce_done) begin
                        cnt   <= 32'd0;
                        state <= S_GAP;
                    end else if (cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        cfg_busy    <= 1'b0;
                        cfg_done    <= 1'b1;
                        cnt         <= 32'd0;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DELAY: begin
                    if (cnt == dly_len - 32'd1) begin
                        cnt   <= 32'd0;
                        state <= S_NEXT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= 32'd0;
                        state <= S_NEXT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_NEXT: begin
                    if (cfg_index == LAST_IDX) begin
                        cfg_busy <= 1'b0;
                        cfg_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cfg_index <= cfg_index + 8'd1;
                        state     <= S_FETCH1;
                    end
                end
                S_DONE: begin
                    if (cfg_start) begin
                        timeout_err <= 1'b0;
                        cfg_done    <= 1'b0;
                        cfg_busy    <= 1'b1;
                        cfg_index   <= 8'd0;
                        state       <= S_FETCH1;
                    end
                end
                default: state <= S_PWR;
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Directed bench for ov5640_cfg_seq with a 1-cycle-latency table ROM and a hand-driven I2C done pulse.
module tb_ov5640_cfg_seq;

    localparam logic [3:0] ST_PWR    = 4'd0;
    localparam logic [3:0] ST_FETCH1 = 4'd1;
    localparam logic [3:0] ST_WAIT   = 4'd4;
    localparam logic [3:0] ST_DELAY  = 4'd5;

    logic        clk_4x = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_start = 1'b0;
    logic        iic_exce_done = 1'b0;
    logic [23:0] cfg_data;
    logic [7:0]  cfg_index;
    logic        iic_exce_st;
    logic [7:0]  iic_dev_addr;
    logic        iic_ctrl_w_r;
    logic        iic_addr_bit;
    logic [2:0]  iic_wr_model;
    logic        iic_series;
    logic [15:0] iic_data_addr;
    logic [7:0]  iic_data_in;
    logic        cfg_busy;
    logic        cfg_done;
    logic        timeout_err;
    logic [3:0]  cfg_state;

    logic [23:0] rom [0:3];
    int n_vec = 0;
    int n_err = 0;

    ov5640_cfg_seq #(
        .DEV_ADDR(8'h78), .REG_NUM(3), .PWR_WAIT(10), .GAP(4), .DLY_UNIT(5), .TIMEOUT(50)
    ) dut (
        .clk_4x(clk_4x), .rst(rst), .cfg_start(cfg_start), .cfg_index(cfg_index),
        .cfg_data(cfg_data), .iic_exce_st(iic_exce_st), .iic_dev_addr(iic_dev_addr),
        .iic_ctrl_w_r(iic_ctrl_w_r), .iic_addr_bit(iic_addr_bit), .iic_wr_model(iic_wr_model),
        .iic_series(iic_series), .iic_data_addr(iic_data_addr), .iic_data_in(iic_data_in),
        .iic_exce_done(iic_exce_done), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .timeout_err(timeout_err), .cfg_state(cfg_state)
    );

    // Clock and table ROM with one cycle of read latency
    always #5 clk_4x = ~clk_4x;
    always @(posedge clk_4x) cfg_data <= rom[cfg_index[1:0]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic wait_st(input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk_4x);
            if (iic_exce_st) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic pulse_done;
        iic_exce_done = 1'b1;
        @(negedge clk_4x);
        iic_exce_done = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk_4x);
        n_vec++; if (cfg_state !== ST_PWR) begin n_err++; $display("FAIL reset_state got %0d exp %0d", cfg_state, ST_PWR); end
        n_vec++; if (cfg_index !== 8'd0) begin n_err++; $display("FAIL reset_index got %0d exp 0", cfg_index); end
        n_vec++; if (iic_exce_st !== 1'b0) begin n_err++; $display("FAIL reset_st got %b exp 0", iic_exce_st); end
        n_vec++; if ({iic_data_addr, iic_data_in} !== 24'h0) begin n_err++; $display("FAIL reset_addr_data got %h exp 000000", {iic_data_addr, iic_data_in}); end
        n_vec++; if ({cfg_busy, cfg_done, timeout_err} !== 3'b100) begin n_err++; $display("FAIL reset_flags got %b exp 100", {cfg_busy, cfg_done, timeout_err}); end
        n_vec++; if ({iic_dev_addr, iic_ctrl_w_r, iic_addr_bit, iic_wr_model, iic_series} !== {8'h78, 1'b0, 1'b1, 3'b001, 1'b0})
            begin n_err++; $display("FAIL const_outputs got %h", {iic_dev_addr, iic_ctrl_w_r, iic_addr_bit, iic_wr_model, iic_series}); end
    endtask

    task automatic test_sequence;
        int k, st_cnt, dly_cnt, done_at;
        rom = '{24'h300842, 24'h310311, 24'hFFFF02, 24'h000000};
        rst = 1'b1;
        wait_st(40, k);
        n_vec++; if (k !== 12) begin n_err++; $display("FAIL first_st_latency got %0d exp 12", k); end
        n_vec++; if ({iic_data_addr, iic_data_in} !== 24'h300842) begin n_err++; $display("FAIL entry0 got %h exp 300842", {iic_data_addr, iic_data_in}); end
        @(negedge clk_4x);
        n_vec++; if (iic_exce_st !== 1'b0 || cfg_state !== ST_WAIT) begin n_err++; $display("FAIL st_width got st=%b state=%0d exp st=0 state=4", iic_exce_st, cfg_state); end
        repeat (2) @(negedge clk_4x);
        n_vec++; if ({iic_data_addr, iic_data_in} !== 24'h300842) begin n_err++; $display("FAIL hold_in_wait got %h exp 300842", {iic_data_addr, iic_data_in}); end
        pulse_done();
        wait_st(40, k);
        n_vec++; if (k !== 7) begin n_err++; $display("FAIL gap_to_second got %0d exp 7", k); end
        n_vec++; if ({iic_data_addr, iic_data_in} !== 24'h310311) begin n_err++; $display("FAIL entry1 got %h exp 310311", {iic_data_addr, iic_data_in}); end
        @(negedge clk_4x);
        pulse_done();
        st_cnt = 0; dly_cnt = 0; done_at = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_4x);
            if (iic_exce_st) st_cnt++;
            if (cfg_state == ST_DELAY) dly_cnt++;
            if (cfg_done && done_at < 0) done_at = i;
        end
        n_vec++; if (st_cnt !== 0) begin n_err++; $display("FAIL marker_no_st got %0d exp 0", st_cnt); end
        n_vec++; if (dly_cnt !== 10) begin n_err++; $display("FAIL marker_delay got %0d exp 10", dly_cnt); end
        n_vec++; if (done_at !== 18) begin n_err++; $display("FAIL done_latency got %0d exp 18", done_at); end
        n_vec++; if ({cfg_index, cfg_busy, timeout_err} !== {8'd2, 1'b0, 1'b0}) begin n_err++; $display("FAIL done_status got idx=%0d busy=%b to=%b exp 2 0 0", cfg_index, cfg_busy, timeout_err); end
    endtask

    task automatic test_timeout_and_ignored_start;
        int k, st_cnt, done_at;
        cfg_start = 1'b1;
        @(negedge clk_4x);
        cfg_start = 1'b0;
        n_vec++; if (cfg_state !== ST_FETCH1 || cfg_index !== 8'd0 || {cfg_busy, cfg_done} !== 2'b10)
            begin n_err++; $display("FAIL restart got state=%0d idx=%0d busy/done=%b exp 1 0 10", cfg_state, cfg_index, {cfg_busy, cfg_done}); end
        wait_st(10, k);
        n_vec++; if (k !== 2) begin n_err++; $display("FAIL restart_no_pwr got %0d exp 2", k); end
        st_cnt = 0; done_at = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk_4x);
            if (i == 20) cfg_start = 1'b1;
            if (i == 21) begin
                cfg_start = 1'b0;
                n_vec++; if (cfg_state !== ST_WAIT || cfg_index !== 8'd0 || cfg_busy !== 1'b1)
                    begin n_err++; $display("FAIL start_in_wait got state=%0d idx=%0d busy=%b exp 4 0 1", cfg_state, cfg_index, cfg_busy); end
            end
            if (iic_exce_st) st_cnt++;
            if (cfg_done && done_at < 0) done_at = i;
        end
        n_vec++; if (done_at !== 51) begin n_err++; $display("FAIL timeout_latency got %0d exp 51", done_at); end
        n_vec++; if (st_cnt !== 0) begin n_err++; $display("FAIL st_repeat_in_wait got %0d exp 0", st_cnt); end
        n_vec++; if ({timeout_err, cfg_done, cfg_busy} !== 3'b110) begin n_err++; $display("FAIL timeout_flags got %b exp 110", {timeout_err, cfg_done, cfg_busy}); end
    endtask

    task automatic test_restart_clears;
        int k;
        cfg_start = 1'b1;
        @(negedge clk_4x);
        cfg_start = 1'b0;
        n_vec++; if (timeout_err !== 1'b0 || cfg_index !== 8'd0 || cfg_state !== ST_FETCH1)
            begin n_err++; $display("FAIL start_clears got to=%b idx=%0d state=%0d exp 0 0 1", timeout_err, cfg_index, cfg_state); end
        wait_st(10, k);
        n_vec++; if (k !== 2 || {iic_data_addr, iic_data_in} !== 24'h300842)
            begin n_err++; $display("FAIL restart_entry0 got k=%0d ad=%h exp 2 300842", k, {iic_data_addr, iic_data_in}); end
    endtask

    task automatic test_reset_mid;
        int k;
        @(negedge clk_4x);
        pulse_done();
        wait_st(20, k);
        n_vec++; if (k !== 7 || {iic_data_addr, iic_data_in} !== 24'h310311)
            begin n_err++; $display("FAIL pre_reset_entry1 got k=%0d ad=%h exp 7 310311", k, {iic_data_addr, iic_data_in}); end
        @(negedge clk_4x);
        #2 rst = 1'b0;
        #1;
        n_vec++; if ({cfg_state, cfg_index, iic_exce_st, iic_data_addr, iic_data_in, cfg_busy, cfg_done, timeout_err} !== {ST_PWR, 8'd0, 1'b0, 16'd0, 8'd0, 1'b1, 1'b0, 1'b0})
            begin n_err++; $display("FAIL async_reset got state=%0d idx=%0d st=%b ad=%h flags=%b", cfg_state, cfg_index, iic_exce_st, {iic_data_addr, iic_data_in}, {cfg_busy, cfg_done, timeout_err}); end
        @(negedge clk_4x);
        rst = 1'b1;
        wait_st(40, k);
        n_vec++; if (k !== 12 || {iic_data_addr, iic_data_in} !== 24'h300842)
            begin n_err++; $display("FAIL post_reset_entry0 got k=%0d ad=%h exp 12 300842", k, {iic_data_addr, iic_data_in}); end
    endtask

    task automatic test_zero_delay;
        int k, dly_cnt, done_at;
        rst = 1'b0;
        rom = '{24'hFFFF00, 24'h123456, 24'hABCDEF, 24'h000000};
        repeat (2) @(negedge clk_4x);
        rst = 1'b1;
        k = -1; dly_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_4x);
            if (cfg_state == ST_DELAY) dly_cnt++;
            if (iic_exce_st) begin k = i; break; end
        end
        n_vec++; if (k !== 15 || dly_cnt !== 0) begin n_err++; $display("FAIL zero_delay got k=%0d dly=%0d exp 15 0", k, dly_cnt); end
        n_vec++; if ({iic_data_addr, iic_data_in} !== 24'h123456) begin n_err++; $display("FAIL rom_entry1 got %h exp 123456", {iic_data_addr, iic_data_in}); end
        @(negedge clk_4x);
        pulse_done();
        wait_st(20, k);
        n_vec++; if (k !== 7 || {iic_data_addr, iic_data_in} !== 24'hABCDEF)
            begin n_err++; $display("FAIL rom_entry2 got k=%0d ad=%h exp 7 abcdef", k, {iic_data_addr, iic_data_in}); end
        @(negedge clk_4x);
        pulse_done();
        done_at = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_4x);
            if (cfg_done && done_at < 0) done_at = i;
        end
        n_vec++; if (done_at !== 5 || cfg_index !== 8'd2) begin n_err++; $display("FAIL last_entry_done got at=%0d idx=%0d exp 5 2", done_at, cfg_index); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_timeout_and_ignored_start();
        test_restart_clears();
        test_reset_mid();
        test_zero_delay();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ov5640_cfg_seq.md
Name: ov5640_cfg_seq

Overview:
- Register-initialisation sequencer that sits directly upstream of the I2C master and drives its command inputs.
- After power-up it walks an external configuration table of {reg_addr[15:0], reg_data[7:0]} entries and issues one single-byte, 16-bit-address write per entry.
- Entries with reg_addr 16'hFFFF are delay markers; no I2C traffic is issued for them.
- Signals completion to the camera capture path, which stays idle until cfg_done is high.

Parameters:
- DEV_ADDR, 8'h78, OV5640 write address driven on iic_dev_addr.
- REG_NUM, 8'd250, number of table entries (1..255).
- PWR_WAIT, 1_000_000, clk_4x cycles to wait after reset release before the first entry (20 ms at 50 MHz).
- GAP, 100, idle cycles between the iic_exce_done pulse and the next fetch.
- DLY_UNIT, 50_000, clk_4x cycles per delay-marker count (1 ms).
- TIMEOUT, 20_000, maximum cycles spent waiting for iic_exce_done.

Ports:
- clk_4x, input, 1, system clock (50 MHz).
- rst, input, 1, asynchronous reset, active low. One clock domain, clk_4x; all state is reset asynchronously by rst low.
- cfg_start, input, 1, one-cycle pulse that restarts the sequence from entry 0 (honoured only in DONE).
- cfg_index, output, 8, current table index.
- cfg_data, input, 24, table entry {addr[15:0], data[7:0]}; read latency is 0 or 1 cycle.
- iic_exce_st, output, 1, one-cycle start pulse to the I2C master.
- iic_dev_addr, output, 8, constant DEV_ADDR.
- iic_ctrl_w_r, output, 1, constant 0 (write).
- iic_addr_bit, output, 1, constant 1 (16-bit address).
- iic_wr_model, output, 3, constant 3'b001 (single write).
- iic_series, output, 1, constant 0.
- iic_data_addr, output, 16, latched entry address.
- iic_data_in, output, 8, latched entry data.
- iic_exce_done, input, 1, one-cycle done pulse from the I2C master.
- cfg_busy, output, 1, high from reset release until DONE.
- cfg_done, output, 1, high while in DONE.
- timeout_err, output, 1, sticky flag: an I2C transaction timed out.

Behaviour:
- Reset values (rst low, asynchronous): state PWR; cfg_index 0; iic_exce_st 0; iic_data_addr 0; iic_data_in 0; cfg_busy 1; cfg_done 0; timeout_err 0; all counters 0.
- Reset mid-transaction aborts immediately; the sequence restarts from PWR.
- PWR: count PWR_WAIT cycles, then go to FETCH.
- FETCH: two cycles. Cycle 1 holds cfg_index stable. Cycle 2 latches cfg_data into an internal entry register. Then:
  - entry addr == 16'hFFFF: go to DELAY.
  - otherwise: go to ISSUE.
- ISSUE: one cycle.
  - iic_data_addr and iic_data_in are updated from the latched entry in the ISSUE cycle.
  - iic_exce_st = 1 for exactly that cycle.
  - Next state WAIT.
- WAIT:
  - iic_data_addr and iic_data_in hold constant until iic_exce_done is seen; the I2C master samples them throughout the transaction.
  - On iic_exce_done: go to GAP.
  - If TIMEOUT cycles elapse without iic_exce_done: set timeout_err and go to DONE (abort).
  - An iic_exce_done seen in any state other than WAIT is ignored.
- DELAY: wait data*DLY_UNIT cycles; data==0 gives zero wait. Then go to NEXT.
- GAP: wait GAP cycles, then go to NEXT.
- NEXT: one cycle.
  - If cfg_index == REG_NUM-1: go to DONE.
  - Otherwise: cfg_index +1, go to FETCH.
- DONE: cfg_busy = 0, cfg_done = 1, cfg_index holds.
  - On cfg_start: clear timeout_err and cfg_done, set cfg_index 0, cfg_busy 1, go to FETCH (no PWR wait).
  - cfg_start in any other state is ignored.
- Counters: the delay counter is 32 bits wide; data*DLY_UNIT must not overflow 32 bits.
- The iic_exce_st pulse never repeats while WAIT is active.

Test Plan:
- Bench parameters: PWR_WAIT=10, GAP=4, DLY_UNIT=5, REG_NUM=3.
- Table {300842,310311,FFFF02}:
  - first iic_exce_st occurs 10 cycles after reset release plus FETCH (2) + ISSUE, with iic_data_addr=3008, iic_data_in=42;
  - after the model's done pulse, the second write (3103/11) starts at least 4+3 cycles later;
  - the marker produces a 10-cycle wait;
  - cfg_done rises, cfg_index=2.
- Model holds done for 200 cycles with TIMEOUT=50: timeout_err=1 and cfg_done=1 at cycle 50 of WAIT; only one iic_exce_st pulse.
- In DONE, pulse cfg_start: timeout_err clears, cfg_index=0, FETCH begins next cycle, no PWR wait.
- Pulse cfg_start during WAIT: ignored, no state change.
- Drive rst low during WAIT of entry 1: all outputs return to reset values asynchronously; after release the PWR wait runs again and entry 0 is reissued.
- ROM model with 1-cycle latency: the latched address/data equal the table entry for every index.
- Table entry FFFF00: zero-length delay, proceeds directly to NEXT, no iic_exce_st.
